// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Memory/IO target for the 6502 core bus. Decodes the 16-bit CPU address
//   into an I/O register window, ROM and RAM, in that priority order.
//   Addresses that hit none of them read 0xFF.
//   The I/O window holds an LED register and a prescaled 16-bit interval
//   timer whose expiry flag, gated by IRQEN, drives the CPU IRQ.
//
//   Bus protocol: there is no handshake. Every clk edge samples cpu_addr.
//   If cpu_we is high at that edge, cpu_data_out is committed to that
//   address. Independently of cpu_we, cpu_data_in is loaded with the
//   pre-edge contents of that address, so read latency is one cycle and a
//   write cycle returns the old data.
//
//   ROM image: a built-in image of 0xEA (NOP) with the NMI, RESET and IRQ
//   vectors all set to RESET_VEC. When ROM_FILE is non-empty, the vectors
//   are not patched and the ROM reads as all NOPs.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   cpu_addr     in   [15:0] CPU address bus (AB)
//   cpu_data_out in   [7:0]  CPU write data (DO)
//   cpu_we       in   CPU write enable (WE)
//   cpu_data_in  out  [7:0]  registered read data to the CPU (DI)
//   cpu_irq      out  level IRQ, active high, registered
//   led_r/g/b    out  LED register bits 0/1/2
module cpu_bus_responder #(
    parameter int          RAM_AW    = 12,
    parameter int          ROM_AW    = 12,
    parameter string       ROM_FILE  = "",
    parameter logic [15:0] RESET_VEC = 16'hF000,
    parameter logic [15:0] IO_BASE   = 16'hD000,
    parameter int          PRESCALE  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_irq,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b
);

    localparam int              PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_MAX   = PW'(PRESCALE - 1);
    localparam logic [16:0]     ROM_START   = 17'h10000 - (17'd1 << ROM_AW);
    localparam logic [16:0]     RAM_END     = 17'd1 << RAM_AW;
    localparam bit              ROM_BUILTIN = (ROM_FILE == "");

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] b;
        b = 8'hEA;
        if (ROM_BUILTIN) begin
            case (a)
                16'hFFFA, 16'hFFFC, 16'hFFFE: b = RESET_VEC[7:0];
                16'hFFFB, 16'hFFFD, 16'hFFFF: b = RESET_VEC[15:8];
                default:                      b = 8'hEA;
            endcase
        end
        return b;
    endfunction

    // Storage and registers
    logic [7:0]    ram_q [2**RAM_AW];
    logic [7:0]    rdata_q,  rdata_d;
    logic [2:0]    led_q,    led_d;
    logic [15:0]   reload_q, reload_d;
    logic [15:0]   count_q,  count_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          en_q,     en_d;
    logic          irqen_q,  irqen_d;
    logic          exp_q,    exp_d;
    logic          irq_q,    irq_d;

    // Decode
    logic       io_sel, rom_sel, ram_sel, ram_wr;
    logic       led_wr, tlo_wr, thi_wr, ctrl_wr, stat_wr;
    logic       tick;
    logic [3:0] io_off;

    always_comb begin
        io_sel  = (cpu_addr[15:4] == IO_BASE[15:4]);
        rom_sel = ({1'b0, cpu_addr} >= ROM_START);
        ram_sel = ({1'b0, cpu_addr} < RAM_END);
        io_off  = cpu_addr[3:0];
        ram_wr  = cpu_we & ram_sel & ~io_sel & ~rom_sel;
        led_wr  = cpu_we & io_sel & (io_off == 4'd0);
        tlo_wr  = cpu_we & io_sel & (io_off == 4'd1);
        thi_wr  = cpu_we & io_sel & (io_off == 4'd2);
        ctrl_wr = cpu_we & io_sel & (io_off == 4'd3);
        stat_wr = cpu_we & io_sel & (io_off == 4'd4);
    end

    // Read mux: pre-edge contents of the sampled address
    always_comb begin
        rdata_d = 8'hFF;
        if (io_sel) begin
            case (io_off)
                4'd0:    rdata_d = {5'b0, led_q};
                4'd1:    rdata_d = count_q[7:0];
                4'd2:    rdata_d = count_q[15:8];
                4'd3:    rdata_d = {6'b0, irqen_q, en_q};
                4'd4:    rdata_d = {7'b0, exp_q};
                default: rdata_d = 8'h00;
            endcase
        end else if (rom_sel) begin
            rdata_d = rom_byte(cpu_addr);
        end else if (ram_sel) begin
            rdata_d = ram_q[cpu_addr[RAM_AW-1:0]];
        end
    end

    // Register file and timer
    always_comb begin
        led_d    = led_wr ? cpu_data_out[2:0] : led_q;
        reload_d = reload_q;
        if (tlo_wr) reload_d[7:0]  = cpu_data_out;
        if (thi_wr) reload_d[15:8] = cpu_data_out;
        en_d     = ctrl_wr ? cpu_data_out[0] : en_q;
        irqen_d  = ctrl_wr ? cpu_data_out[1] : irqen_q;
        count_d  = count_q;
        presc_d  = presc_q;
        exp_d    = exp_q;

        // A CTRL write with EN=0 stops the timer in the write cycle itself,
        // so a tick that would fall on that edge is suppressed.
        tick = en_q & en_d & (presc_q == PRESC_MAX);

        if (ctrl_wr && cpu_data_out[0] && !en_q) begin
            count_d = reload_q;
            presc_d = '0;
        end else if (!en_d) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            count_d = (count_q == 16'd0) ? reload_q : count_q - 16'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Expiry is applied after the clear so that it wins on a collision.
        if (stat_wr && cpu_data_out[0]) exp_d = 1'b0;
        if (tick && count_q == 16'd0)   exp_d = 1'b1;

        irq_d = exp_q & irqen_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q  <= 8'h00;
            led_q    <= 3'b000;
            reload_q <= 16'h0000;
            count_q  <= 16'h0000;
            presc_q  <= '0;
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
            exp_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            irqen_q  <= irqen_d;
            exp_q    <= exp_d;
            irq_q    <= irq_d;
        end
    end

    // RAM contents survive reset; a write sampled while reset is low is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && ram_wr) begin
            ram_q[cpu_addr[RAM_AW-1:0]] <= cpu_data_out;
        end
    end

    assign cpu_data_in = rdata_q;
    assign cpu_irq     = irq_q;
    assign led_r       = led_q[0];
    assign led_g       = led_q[1];
    assign led_b       = led_q[2];

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_we;
  logic [7:0]  cpu_data_in;
  logic        cpu_irq;
  logic        led_r, led_g, led_b;

  always #5 clk = ~clk;

  cpu_bus_responder #(
    .RAM_AW(12), .ROM_AW(12), .ROM_FILE(""), .RESET_VEC(16'hF000),
    .IO_BASE(16'hD000), .PRESCALE(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .cpu_data_in(cpu_data_in), .cpu_irq(cpu_irq),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] ram_model [8];
  logic [15:0] ram_addr [8];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns after the capturing posedge.
  // When rd is set the expected DI is queued and popped once the DUT has produced it.
  task automatic cyc(input logic [15:0] a, input logic we, input logic [7:0] d,
                     input logic rd, input logic [7:0] e, input string tag);
    @(negedge clk);
    cpu_addr     = a;
    cpu_we       = we;
    cpu_data_out = d;
    if (rd) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    if (rd) begin
      check_val(tag_q.pop_front(), {8'h00, cpu_data_in}, {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, 1'b1, d, 1'b0, 8'h00, "");
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] e, input string tag);
    cyc(a, 1'b0, 8'h00, 1'b1, e, tag);
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "");
  endtask

  initial begin
    reset_n      = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_we       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_di",  {8'h00, cpu_data_in}, 16'h0000);
    check_val("rst_irq", {15'h0, cpu_irq}, 16'h0000);
    check_val("rst_led", {13'h0, led_b, led_g, led_r}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // vectors and ROM fill
    rd_chk(16'hFFFC, 8'h00, "vec_rst_lo");
    rd_chk(16'hFFFD, 8'hF0, "vec_rst_hi");
    rd_chk(16'hF123, 8'hEA, "rom_nop");
    rd_chk(16'hFFFA, 8'h00, "vec_nmi_lo");
    rd_chk(16'hFFFF, 8'hF0, "vec_irq_hi");

    // RAM, ROM write ignored, unmapped
    wr(16'h0123, 8'h5A);
    rd_chk(16'h0123, 8'h5A, "ram_rd");
    cyc(16'h0123, 1'b1, 8'h77, 1'b1, 8'h5A, "ram_wr_old");
    rd_chk(16'h0123, 8'h77, "ram_rd2");
    wr(16'hF000, 8'h11);
    rd_chk(16'hF000, 8'hEA, "rom_wr_ign");
    rd_chk(16'h8000, 8'hFF, "unmapped");
    rd_chk(16'h1000, 8'hFF, "ram_top");

    // random RAM traffic against a small model
    for (int i = 0; i < 8; i++) begin
      ram_addr[i]  = 16'($urandom_range(0, 4095));
      while (ram_addr[i] == 16'h0123) ram_addr[i] = 16'($urandom_range(0, 4095));
      for (int j = 0; j < i; j++)
        if (ram_addr[j] == ram_addr[i]) ram_addr[i] = 16'h0200 + 16'(i);
      ram_model[i] = 8'($urandom_range(0, 255));
      wr(ram_addr[i], ram_model[i]);
    end
    for (int i = 0; i < 30; i++) begin
      int idx;
      logic [7:0] nd;
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        nd = 8'($urandom_range(0, 255));
        cyc(ram_addr[idx], 1'b1, nd, 1'b1, ram_model[idx], "ram_rand_wr");
        ram_model[idx] = nd;
      end else begin
        rd_chk(ram_addr[idx], ram_model[idx], "ram_rand_rd");
      end
    end

    // LED register
    wr(16'hD000, 8'h05);
    check_val("led_pins", {13'h0, led_b, led_g, led_r}, 16'h0005);
    rd_chk(16'hD000, 8'h05, "led_rd");
    wr(16'hD000, 8'hFF);
    rd_chk(16'hD000, 8'h07, "led_rd_mask");
    rd_chk(16'hD00F, 8'h00, "io_unused");

    // timer: reload=2, PRESCALE=4 -> expiry 12 clk after enable
    wr(16'hD001, 8'h02);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h03);                       // edge E0
    for (int k = 1; k <= 37; k++) begin
      if (k == 5)       rd_chk(16'hD001, 8'h01, "cnt_lo");
      else if (k == 12) rd_chk(16'hD004, 8'h00, "exp_before");
      else if (k == 13) rd_chk(16'hD004, 8'h01, "exp_set");
      else if (k == 14) wr(16'hD004, 8'h01);  // clear EXP
      else if (k == 36) wr(16'hD004, 8'h01);  // clear collides with expiry
      else if (k == 37) rd_chk(16'hD004, 8'h01, "exp_set_wins");
      else              idle();
      if (k == 12) check_val("irq_e12", {15'h0, cpu_irq}, 16'h0000);
      if (k == 13) check_val("irq_e13", {15'h0, cpu_irq}, 16'h0001);
      if (k == 15) check_val("irq_clr", {15'h0, cpu_irq}, 16'h0000);
      if (k == 24) check_val("irq_e24", {15'h0, cpu_irq}, 16'h0000);
      if (k == 25) check_val("irq_refire", {15'h0, cpu_irq}, 16'h0001);
      if (k == 37) check_val("irq_e37", {15'h0, cpu_irq}, 16'h0001);
    end

    // async reset with the timer running
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_irq", {15'h0, cpu_irq}, 16'h0000);
    check_val("arst_di",  {8'h00, cpu_data_in}, 16'h0000);
    check_val("arst_led", {13'h0, led_b, led_g, led_r}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk(16'hD003, 8'h00, "arst_ctrl");
    rd_chk(16'hD004, 8'h00, "arst_stat");
    rd_chk(16'hD001, 8'h00, "arst_cnt");
    rd_chk(16'h0123, 8'h77, "ram_kept");

    // IRQEN=0 masks; reload=0 expires every tick
    wr(16'hD003, 8'h01);                       // E0: count=0
    for (int k = 1; k <= 7; k++) begin
      if (k == 5)      rd_chk(16'hD004, 8'h01, "exp_masked");
      else if (k == 6) wr(16'hD003, 8'h03);
      else             idle();
      if (k == 5) check_val("irq_masked", {15'h0, cpu_irq}, 16'h0000);
      if (k == 6) check_val("irq_unmask0", {15'h0, cpu_irq}, 16'h0000);
      if (k == 7) check_val("irq_unmask1", {15'h0, cpu_irq}, 16'h0001);
    end
    wr(16'hD003, 8'h02);                       // IRQEN only: masks nothing, EN off
    idle();
    check_val("irq_en_off", {15'h0, cpu_irq}, 16'h0001);
    wr(16'hD003, 8'h00);
    idle();
    check_val("irq_gate_off", {15'h0, cpu_irq}, 16'h0000);

    // freeze keeps count
    wr(16'hD001, 8'h10);
    wr(16'hD003, 8'h01);                       // G0: count=0x10
    for (int k = 1; k <= 4; k++) idle();      // tick at G4 -> 0x0F
    wr(16'hD003, 8'h00);                       // G5: freeze
    for (int k = 0; k < 10; k++) idle();
    rd_chk(16'hD001, 8'h0F, "freeze_cnt");
    rd_chk(16'hD002, 8'h00, "freeze_cnt_hi");

    check_val("sb_empty", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
